// File: rtl/sap_controller_sequencer.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring, control-word decode and halt detection.
// Optional `SAP_SINGLE_STEP_EN adds RUN/STEP inputs for manual single-stepping.
module sap_controller_sequencer #(
   parameter logic [3:0] OP_LDA = 4'h0,
   parameter logic [3:0] OP_ADD = 4'h1,
   parameter logic [3:0] OP_SUB = 4'h2,
   parameter logic [3:0] OP_OUT = 4'hE,
   parameter logic [3:0] OP_HLT = 4'hF
) (
   input  logic       CLK,
   input  logic       CLR_,
`ifdef SAP_SINGLE_STEP_EN
   input  logic       RUN,
   input  logic       STEP,
`endif
   input  logic [3:0] opcode,
   output logic [5:0] T,
   output logic       Cp,
   output logic       Ep,
   output logic       Lm_,
   output logic       CE_,
   output logic       Li_,
   output logic       Ei_,
   output logic       La_,
   output logic       Ea,
   output logic       Su,
   output logic       Eu,
   output logic       Lb_,
   output logic       Lo_,
   output logic       HLT
);

   typedef enum logic [5:0] {
      StT1 = 6'b000001,
      StT2 = 6'b000010,
      StT3 = 6'b000100,
      StT4 = 6'b001000,
      StT5 = 6'b010000,
      StT6 = 6'b100000
   } state_e;

   state_e state_q, state_d;
   logic   hlt_q, hlt_d;
   logic   advance;

`ifdef SAP_SINGLE_STEP_EN
   logic step_q;

   always_ff @(posedge CLK) begin
      if (!CLR_) begin
         step_q <= 1'b0;
      end else begin
         step_q <= STEP;
      end
   end

   assign advance = RUN | (STEP & ~step_q);
`else
   assign advance = 1'b1;
`endif

   always_ff @(posedge CLK) begin
      if (!CLR_) begin
         state_q <= StT1;
         hlt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hlt_q   <= hlt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hlt_d   = hlt_q;
      if (!hlt_q && advance) begin
         unique case (state_q)
            StT1: state_d = StT2;
            StT2: state_d = StT3;
            StT3: state_d = StT4;
            StT4: begin
               // Halt freezes the ring in T4 until reset.
               if (opcode == OP_HLT) begin
                  hlt_d = 1'b1;
               end else begin
                  state_d = StT5;
               end
            end
            StT5: state_d = StT6;
            StT6: state_d = StT1;
            default: state_d = StT1;
         endcase
      end
   end

   always_comb begin
      Cp  = 1'b0;
      Ep  = 1'b0;
      Lm_ = 1'b1;
      CE_ = 1'b1;
      Li_ = 1'b1;
      Ei_ = 1'b1;
      La_ = 1'b1;
      Ea  = 1'b0;
      Su  = 1'b0;
      Eu  = 1'b0;
      Lb_ = 1'b1;
      Lo_ = 1'b1;
      if (!hlt_q) begin
         unique case (state_q)
            StT1: begin
               Ep  = 1'b1;
               Lm_ = 1'b0;
            end
            StT2: Cp = 1'b1;
            StT3: begin
               CE_ = 1'b0;
               Li_ = 1'b0;
            end
            StT4: begin
               if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                  Ei_ = 1'b0;
                  Lm_ = 1'b0;
               end else if (opcode == OP_OUT) begin
                  Ea  = 1'b1;
                  Lo_ = 1'b0;
               end
            end
            StT5: begin
               if (opcode == OP_LDA) begin
                  CE_ = 1'b0;
                  La_ = 1'b0;
               end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                  CE_ = 1'b0;
                  Lb_ = 1'b0;
               end
            end
            StT6: begin
               if (opcode == OP_ADD || opcode == OP_SUB) begin
                  Eu  = 1'b1;
                  La_ = 1'b0;
                  Su  = (opcode == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

   assign T   = state_q;
   assign HLT = hlt_q;

endmodule
